// File: rtl/result_checker.sv
// Snoops the data-memory write bus for test-port writes and checks them against a loadable answer memory.
// Build option: CHECKER_TIMEOUT_EN enables the duration watchdog. o_dbg_state: 0 IDLE, 1 CHECK, 2 REPORT.
`timescale 1ns/1ps
module result_checker #(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT = 'hFF,
    parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h00000168,
    parameter int                DEPTH     = 64,
    parameter int                ERR_W     = 8,
    parameter int                DUR_W     = 16,
    parameter int                BYTE_SWAP = 1,
    parameter int                TIMEOUT   = 'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          data,
    input  logic                       wen,
    input  logic                       ld_en,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic [$clog2(DEPTH+1)-1:0] check_num,
    output logic [ERR_W-1:0]           error_num,
    output logic [DUR_W-1:0]           duration,
    output logic [$clog2(DEPTH)-1:0]   first_err_idx,
    output logic                       first_err_vld,
    output logic                       finish,
    output logic                       pass,
    output logic                       timeout,
    output logic [1:0]                 o_dbg_state
);

    localparam int               CNT_W     = $clog2(DEPTH+1);
    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] L_DEPTH   = CNT_W'(DEPTH);
    localparam logic [ERR_W-1:0] L_ERR_MAX = {{(ERR_W-1){1'b1}}, 1'b0};
`ifdef CHECKER_TIMEOUT_EN
    localparam bit               L_TO_EN   = 1'b1;
`else
    localparam bit               L_TO_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_ld_ptr;
    logic [CNT_W-1:0]  r_idx;
    logic              r_armed;
    logic [ERR_W-1:0]  r_err;
    logic [DUR_W-1:0]  r_dur;
    logic [IDX_W-1:0]  r_fidx;
    logic              r_fvld;
    logic              r_finish;
    logic              r_pass;
    logic              r_timeout;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_swapped;
    logic [DATA_W-1:0] w_d;
    logic [DATA_W-1:0] w_mem_rd;
    logic [CNT_W-1:0]  w_limit;
    logic              w_port_wr;
    logic              w_accept;
    logic              w_ld_wr;
    logic              w_to_hit;

    // Bus data arrives little-endian; answers are stored in readable order.
    always_comb begin
        w_swapped = data;
        for (int b = 0; b < DATA_W/8; b++) begin
            w_swapped[b*8 +: 8] = data[DATA_W-8-b*8 +: 8];
        end
    end

    assign w_d       = (BYTE_SWAP != 0) ? w_swapped : data;
    assign w_port_wr = wen && (addr == TEST_PORT);
    assign w_accept  = w_port_wr && r_armed;
    assign w_limit   = (check_num < L_DEPTH) ? check_num : L_DEPTH;
    assign w_mem_rd  = r_mem[r_idx[IDX_W-1:0]];
    assign w_ld_wr   = rst && ld_en && (r_state == S_IDLE) && (r_ld_ptr != L_DEPTH);
    assign w_to_hit  = L_TO_EN && (r_dur == DUR_W'(TIMEOUT));

    // Answer memory has no reset so a rerun after reset can reuse it.
    always_ff @(posedge clk) begin
        if (w_ld_wr) begin
            r_mem[r_ld_ptr[IDX_W-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ld_ptr  <= '0;
            r_idx     <= '0;
            r_armed   <= 1'b0;
            r_err     <= '1;
            r_dur     <= '0;
            r_fidx    <= '0;
            r_fvld    <= 1'b0;
            r_finish  <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // A stalled write keeps wen high; only the first cycle of it is accepted.
            r_armed <= ~wen;
            if (w_ld_wr) begin
                r_ld_ptr <= r_ld_ptr + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_port_wr && (w_d == BEGIN_SYM)) begin
                        r_state <= S_CHECK;
                        r_err   <= '0;
                        r_dur   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_CHECK: begin
                    if (w_to_hit) begin
                        r_state   <= S_REPORT;
                        r_finish  <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end else begin
                        if (r_dur != '1) begin
                            r_dur <= r_dur + DUR_W'(1);
                        end
                        if (r_idx == w_limit) begin
                            r_state  <= S_REPORT;
                            r_finish <= 1'b1;
                            r_pass   <= (r_err == '0);
                        end else if (w_accept) begin
                            r_idx <= r_idx + CNT_W'(1);
                            if (w_d != w_mem_rd) begin
                                // All-ones is reserved for "not started".
                                if (r_err != L_ERR_MAX) begin
                                    r_err <= r_err + ERR_W'(1);
                                end
                                if (!r_fvld) begin
                                    r_fidx <= r_idx[IDX_W-1:0];
                                    r_fvld <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_REPORT: begin
                    r_state <= S_REPORT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign error_num     = r_err;
    assign duration      = r_dur;
    assign first_err_idx = r_fidx;
    assign first_err_vld = r_fvld;
    assign finish        = r_finish;
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker: table vectors, hand sequences and randomized runs vs a model.
`timescale 1ns/1ps
module tb_result_checker;

    localparam int          DEPTH     = 64;
    localparam logic [29:0] PORT      = 30'hFF;
    localparam logic [29:0] OTHER     = 30'hFE;
    localparam logic [31:0] BEGIN_SYM = 32'h00000168;
`ifdef CHECKER_TIMEOUT_EN
    localparam int          TO        = 20;
`else
    localparam int          TO        = 'hFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] addr = '0;
    logic [31:0] data = '0;
    logic        wen = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_data = '0;
    logic [6:0]  check_num = '0;
    logic [7:0]  error_num;
    logic [15:0] duration;
    logic [5:0]  first_err_idx;
    logic        first_err_vld;
    logic        finish;
    logic        pass;
    logic        timeout;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    result_checker #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .ld_en(ld_en), .ld_data(ld_data), .check_num(check_num),
        .error_num(error_num), .duration(duration), .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld), .finish(finish), .pass(pass),
        .timeout(timeout), .o_dbg_state(dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          ld_cnt = 0;
    logic [31:0] ans_m [DEPTH];
    logic [31:0] tx_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] w [5];
        int          nchk;
        int          e_err;
        int          e_fidx;
        bit          e_fvld;
        bit          e_pass;
    } vec_t;
    vec_t vecs [7];

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_err", error_num, 32'hFF);
        chk("rst_dur", duration, 0);
        chk("rst_fidx", first_err_idx, 0);
        chk("rst_fvld", first_err_vld, 0);
        chk("rst_finish", finish, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_state", dbg_state, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0; wen = 1'b0; ld_en = 1'b0; addr = '0; data = '0;
        #1;
        chk_reset_vals();
        tick();
        rst = 1'b1;
        ld_cnt = 0;
        tick();
    endtask

    // Model of the answer memory: loads fill from index 0, overflow words are dropped.
    task automatic load_word(input logic [31:0] w);
        ld_en = 1'b1; ld_data = w;
        tick();
        ld_en = 1'b0;
        if (ld_cnt < DEPTH) ans_m[ld_cnt] = w;
        ld_cnt++;
    endtask

    task automatic load_fixed();
        load_word(0); load_word(1); load_word(1); load_word(2); load_word(3);
    endtask

    task automatic send_word(input logic [29:0] a, input logic [31:0] w, input int hold,
                             input int gap, input bit last, output int t_first);
        addr = a; data = bswap(w); wen = 1'b1;
        tick();
        t_first = edge_n;
        if (last) chk("fin_early", finish, 0);
        repeat (hold - 1) tick();
        wen = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_report(input int t_begin, input int t_last);
        int n;
        n = 0;
        while (!finish && n < 300) begin
            tick();
            n++;
        end
        chk("finish", finish, 1);
        chk("fin_edge", edge_n, t_last + 1);
        chk("duration", duration, t_last + 1 - t_begin);
        chk("state_rpt", dbg_state, 2);
    endtask

    // noise: 0 none, 1 before every word, 2 random
    task automatic run_seq(input int nchk, input int hmax, input int noise);
        int t_begin, t_last, tf;
        bit last;
        check_num = 7'(nchk);
        send_word(PORT, BEGIN_SYM, 1, 1, 1'b0, t_begin);
        chk("err_clr", error_num, 0);
        t_last = t_begin;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (noise == 1 || (noise == 2 && $urandom_range(0, 2) == 0)) begin
                addr = OTHER; data = $urandom; wen = 1'b1;
                ld_en = 1'b1; ld_data = $urandom;
                tick();
                wen = 1'b0; ld_en = 1'b0;
                tick();
            end
            last = (i == tx_q.size() - 1);
            send_word(PORT, tx_q[i], last ? 1 : $urandom_range(1, hmax),
                      last ? 1 : $urandom_range(1, 2), last, tf);
            t_last = tf;
        end
        wait_report(t_begin, t_last);
    endtask

    task automatic chk_result(input int e_err, input int e_fidx, input bit e_fvld, input bit e_pass);
        chk("error_num", error_num, e_err);
        chk("first_err_idx", first_err_idx, e_fidx);
        chk("first_err_vld", first_err_vld, e_fvld);
        chk("pass", pass, e_pass);
        chk("timeout", timeout, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb, tl, tf, e_err, e_fidx, nload, nchk;
        bit e_fvld;
        logic [31:0] w;

        vecs[0] = '{'{32'd0, 32'd1, 32'd1, 32'd2, 32'd3}, 5, 0, 0, 1'b0, 1'b1};
        vecs[1] = '{'{32'd0, 32'd1, 32'd7, 32'd2, 32'd9}, 5, 2, 2, 1'b1, 1'b0};
        vecs[2] = '{'{32'd5, 32'd1, 32'd1, 32'd2, 32'd3}, 5, 1, 0, 1'b1, 1'b0};
        vecs[3] = '{'{32'd9, 32'd9, 32'd9, 32'd9, 32'd9}, 5, 5, 0, 1'b1, 1'b0};
        vecs[4] = '{'{32'd0, 32'd1, 32'd1, 32'd0, 32'd0}, 3, 0, 0, 1'b0, 1'b1};
        vecs[5] = '{'{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0, 0, 0, 1'b0, 1'b1};
        vecs[6] = '{'{32'd0, 32'd4, 32'd0, 32'd0, 32'd0}, 2, 1, 1, 1'b1, 1'b0};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            load_fixed();
            tx_q.delete();
            for (int i = 0; i < vecs[v].nchk; i++) tx_q.push_back(vecs[v].w[i]);
            run_seq(vecs[v].nchk, 1, 0);
            chk_result(vecs[v].e_err, vecs[v].e_fidx, vecs[v].e_fvld, vecs[v].e_pass);
        end

`ifdef CHECKER_TIMEOUT_EN
        do_reset();
        load_fixed();
        check_num = 7'd5;
        send_word(PORT, BEGIN_SYM, 1, 1, 1'b0, tb);
        send_word(PORT, 0, 1, 1, 1'b0, tf);
        send_word(PORT, 1, 1, 1, 1'b0, tf);
        tl = 0;
        while (!finish && tl < 100) begin
            tick();
            tl++;
        end
        chk("to_finish", finish, 1);
        chk("to_edge", edge_n, tb + TO + 1);
        chk("to_duration", duration, TO);
        chk("to_timeout", timeout, 1);
        chk("to_pass", pass, 0);
        chk("to_err", error_num, 0);
`else
        // Stalled write counts once.
        do_reset();
        load_fixed();
        check_num = 7'd2;
        send_word(PORT, BEGIN_SYM, 1, 1, 1'b0, tb);
        send_word(PORT, 0, 4, 2, 1'b0, tf);
        chk("stall_once", finish, 0);
        send_word(PORT, 1, 1, 1, 1'b1, tl);
        wait_report(tb, tl);
        chk_result(0, 0, 1'b0, 1'b1);

        // Port writes before begin and off-port writes during CHECK are ignored.
        do_reset();
        load_fixed();
        check_num = 7'd5;
        send_word(PORT, 5, 1, 1, 1'b0, tf);
        send_word(PORT, 6, 1, 1, 1'b0, tf);
        chk("pre_begin_err", error_num, 32'hFF);
        chk("pre_begin_fin", finish, 0);
        tx_q = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
        run_seq(5, 2, 1);
        chk_result(0, 0, 1'b0, 1'b1);

        // Reset mid-run, then rerun against the retained answers.
        do_reset();
        load_fixed();
        check_num = 7'd5;
        send_word(PORT, BEGIN_SYM, 1, 1, 1'b0, tb);
        send_word(PORT, 0, 1, 1, 1'b0, tf);
        send_word(PORT, 9, 1, 1, 1'b0, tf);
        send_word(PORT, 1, 1, 1, 1'b0, tf);
        chk("mid_err", error_num, 1);
        chk("mid_fvld", first_err_vld, 1);
        chk("mid_fidx", first_err_idx, 1);
        rst = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rst = 1'b1;
        ld_cnt = 0;
        tick();
        tx_q = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
        run_seq(5, 1, 0);
        chk_result(0, 0, 1'b0, 1'b1);

        // Randomized runs against the answer-memory model.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            nload = (r == 0 || $urandom_range(0, 1) == 1) ? DEPTH + $urandom_range(0, 3)
                                                         : $urandom_range(1, DEPTH - 1);
            for (int i = 0; i < nload; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                load_word($urandom);
            end
            nchk = $urandom_range(0, DEPTH);
            tx_q.delete();
            exp_q.delete();
            for (int i = 0; i < nchk; i++) begin
                exp_q.push_back(ans_m[i]);
                w = ans_m[i];
                if ($urandom_range(0, 3) == 0) w = w ^ ($urandom | 32'd1);
                tx_q.push_back(w);
            end
            e_err = 0; e_fidx = 0; e_fvld = 1'b0;
            for (int i = 0; i < nchk; i++) begin
                if (tx_q[i] != exp_q[i]) begin
                    if (!e_fvld) e_fidx = i;
                    e_fvld = 1'b1;
                    e_err++;
                end
            end
            run_seq(nchk, 3, 2);
            chk_result(e_err, e_fidx, e_fvld, e_err == 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
